// File: rtl/src_buf_ctrl.sv
// Command sequencer for the asymmetric source buffer: LOAD streams 32-bit host words into port A,
// READ fetches 128-bit rows from port B through a 2-entry FIFO onto a valid/ready stream.
module src_buf_ctrl #(
   parameter int unsigned WIDTHA     = 32,
   parameter int unsigned WIDTHB     = 128,
   parameter int unsigned ADDRWIDTHA = 14,
   parameter int unsigned ADDRWIDTHB = 12,
   parameter int unsigned LEN_W      = 15
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_op,
   input  logic [ADDRWIDTHA-1:0] cmd_base,
   input  logic [LEN_W-1:0]      cmd_len,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [WIDTHA-1:0]     wr_data,
   output logic                  buf_enaA,
   output logic                  buf_weA,
   output logic [ADDRWIDTHA-1:0] buf_addrA,
   output logic [WIDTHA-1:0]     buf_diA,
   output logic                  buf_enaB,
   output logic [ADDRWIDTHB-1:0] buf_addrB,
   input  logic [WIDTHB-1:0]     buf_doB,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [WIDTHB-1:0]     rd_data,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {StIdle, StLoad, StRead, StDone} state_e;

   state_e                r_state;
   state_e                w_state_d;
   logic [LEN_W-1:0]      r_len;
   logic [LEN_W-1:0]      r_cnt;
   logic [LEN_W-1:0]      r_issued;
   logic [ADDRWIDTHA-1:0] r_addr_a;
   logic [ADDRWIDTHB-1:0] r_addr_b;
   logic                  r_inflight;
   logic [1:0]            r_occ;
   logic                  r_wr_ptr;
   logic                  r_rd_ptr;
   logic [WIDTHB-1:0]     r_fifo [2];

   logic                  w_accept;
   logic                  w_wr_hs;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_issue;
   logic                  w_last;
   logic [2:0]            w_level;

   assign cmd_ready = (r_state == StIdle);
   assign wr_ready  = (r_state == StLoad);
   assign busy      = (r_state != StIdle);
   assign done      = (r_state == StDone);

   assign w_accept  = cmd_valid & cmd_ready;
   assign w_wr_hs   = wr_valid & wr_ready;
   assign rd_valid  = (r_occ != 2'd0);
   assign rd_data   = r_fifo[r_rd_ptr];
   assign w_pop     = rd_valid & rd_ready;
   assign w_push    = r_inflight;
   assign w_last    = (r_cnt == r_len - LEN_W'(1));

   // Rows held or already requested, minus the one leaving this cycle, must leave a free slot.
   assign w_level   = {1'b0, r_occ} + {2'b00, r_inflight};
   assign w_issue   = (r_state == StRead) && (r_issued < r_len) &&
                      ((w_level - {2'b00, w_pop}) < 3'd2);
   assign buf_enaB  = w_issue;
   assign buf_addrB = r_addr_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle: begin
            if (w_accept) begin
               if (cmd_len == '0) begin
                  w_state_d = StDone;
               end else if (cmd_op) begin
                  w_state_d = StRead;
               end else begin
                  w_state_d = StLoad;
               end
            end
         end
         StLoad:  if (w_wr_hs && w_last) w_state_d = StDone;
         StRead:  if (w_pop && w_last) w_state_d = StDone;
         StDone:  w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   // Command fields and progress counters; r_cnt counts write or pop handshakes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_len    <= '0;
         r_cnt    <= '0;
         r_issued <= '0;
         r_addr_a <= '0;
         r_addr_b <= '0;
      end else if (w_accept) begin
         r_len    <= cmd_len;
         r_cnt    <= '0;
         r_issued <= '0;
         r_addr_a <= cmd_base;
         r_addr_b <= cmd_base[ADDRWIDTHB-1:0];
      end else begin
         if (w_wr_hs || w_pop) begin
            r_cnt <= r_cnt + LEN_W'(1);
         end
         if (w_wr_hs) begin
            r_addr_a <= r_addr_a + ADDRWIDTHA'(1);
         end
         if (w_issue) begin
            r_issued <= r_issued + LEN_W'(1);
            r_addr_b <= r_addr_b + ADDRWIDTHB'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_enaA  <= 1'b0;
         buf_weA   <= 1'b0;
         buf_addrA <= '0;
         buf_diA   <= '0;
      end else begin
         buf_enaA <= w_wr_hs;
         buf_weA  <= w_wr_hs;
         if (w_wr_hs) begin
            buf_addrA <= r_addr_a;
            buf_diA   <= wr_data;
         end
      end
   end

   // Row data arrives one cycle after issue and is captured straight into the FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inflight <= 1'b0;
         r_occ      <= 2'd0;
         r_wr_ptr   <= 1'b0;
         r_rd_ptr   <= 1'b0;
         r_fifo[0]  <= '0;
         r_fifo[1]  <= '0;
      end else begin
         r_inflight <= w_issue;
         if (w_push) begin
            r_fifo[r_wr_ptr] <= buf_doB;
            r_wr_ptr         <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         if (w_push && !w_pop) begin
            r_occ <= r_occ + 2'd1;
         end else if (!w_push && w_pop) begin
            r_occ <= r_occ - 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_src_buf_ctrl.sv
// Directed bench for src_buf_ctrl with a behavioural dual-port buffer attached to ports A and B.
module tb_src_buf_ctrl;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         cmd_valid, cmd_ready, cmd_op;
   logic [13:0]  cmd_base;
   logic [14:0]  cmd_len;
   logic         wr_valid, wr_ready;
   logic [31:0]  wr_data;
   logic         buf_enaA, buf_weA, buf_enaB;
   logic [13:0]  buf_addrA;
   logic [31:0]  buf_diA;
   logic [11:0]  buf_addrB;
   logic [127:0] buf_doB;
   logic         rd_valid, rd_ready;
   logic [127:0] rd_data;
   logic         busy, done;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   src_buf_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_base(cmd_base), .cmd_len(cmd_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .buf_enaA(buf_enaA), .buf_weA(buf_weA), .buf_addrA(buf_addrA), .buf_diA(buf_diA),
      .buf_enaB(buf_enaB), .buf_addrB(buf_addrB), .buf_doB(buf_doB),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .busy(busy), .done(done)
   );

   // Buffer model: 32-bit write port, 128-bit read port, word 0 of a row in the low bits.
   logic [31:0] mem [0:16383];
   always @(posedge clk) begin
      if (buf_enaA && buf_weA) mem[buf_addrA] <= buf_diA;
      if (buf_enaB) buf_doB <= {mem[{buf_addrB, 2'd3}], mem[{buf_addrB, 2'd2}],
                                mem[{buf_addrB, 2'd1}], mem[{buf_addrB, 2'd0}]};
   end

   // Activity log sampled mid-cycle; occ is the FIFO fill implied by issues and beats.
   logic [13:0] wa_addr [$];
   logic [31:0] wa_data [$];
   logic [11:0] rb_addr [$];
   int done_cnt, port_clash, iss_total, iss_prev, beats, occ, max_occ, valid_err;
   always @(negedge clk) begin
      if (buf_enaA && buf_weA) begin
         wa_addr.push_back(buf_addrA);
         wa_data.push_back(buf_diA);
      end
      if (buf_enaB) rb_addr.push_back(buf_addrB);
      if (buf_enaA && buf_enaB) port_clash++;
      if (done) done_cnt++;
      occ = iss_prev - beats;
      if (occ > max_occ) max_occ = occ;
      if (rd_valid !== (occ > 0)) valid_err++;
      iss_prev = iss_total;
      if (buf_enaB) iss_total++;
      if (rd_valid && rd_ready) beats++;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      wa_addr.delete();
      wa_data.delete();
      rb_addr.delete();
      done_cnt = 0; port_clash = 0; iss_total = 0; iss_prev = 0;
      beats = 0; max_occ = 0; valid_err = 0;
   endtask

   task automatic send_cmd(input logic op, input logic [13:0] base, input logic [14:0] len);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_base  = base;
      cmd_len   = len;
      cyc();
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      n_cmp++;
      if ({cmd_ready, busy, done, wr_ready, buf_enaA, buf_weA, buf_enaB, rd_valid} !== 8'b1000_0000) begin
         n_err++;
         $display("FAIL reset_ctl: got %b expected 10000000",
                  {cmd_ready, busy, done, wr_ready, buf_enaA, buf_weA, buf_enaB, rd_valid});
      end
      n_cmp++;
      if ({buf_addrA, buf_diA, buf_addrB, rd_data} !== '0) begin
         n_err++;
         $display("FAIL reset_data: got %h expected 0", {buf_addrA, buf_diA, buf_addrB, rd_data});
      end
      cyc();
      rst_n = 1'b1;
      cyc();
      send_cmd(1'b0, 14'h0100, 15'd4);
      wr_valid = 1'b1;
      wr_data  = 32'h1111_0000;
      cyc();
      wr_data  = 32'h1111_0001;
      cyc();
      wr_valid = 1'b0;
      n_cmp++;
      if ({buf_enaA, busy} !== 2'b11) begin
         n_err++;
         $display("FAIL midload_active: got %b expected 11", {buf_enaA, busy});
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({cmd_ready, busy, done, wr_ready, buf_enaA, buf_weA, buf_enaB, rd_valid} !== 8'b1000_0000) begin
         n_err++;
         $display("FAIL async_reset_ctl: got %b expected 10000000",
                  {cmd_ready, busy, done, wr_ready, buf_enaA, buf_weA, buf_enaB, rd_valid});
      end
      n_cmp++;
      if ({buf_addrA, buf_diA} !== '0) begin
         n_err++;
         $display("FAIL async_reset_porta: got %h expected 0", {buf_addrA, buf_diA});
      end
      clear_logs();
      cyc();
      cyc();
      rst_n = 1'b1;
      repeat (4) cyc();
      n_cmp++;
      if (done_cnt !== 0 || {cmd_ready, busy} !== 2'b10) begin
         n_err++;
         $display("FAIL reset_no_done: got done_cnt=%0d rdy/busy=%b expected 0/10",
                  done_cnt, {cmd_ready, busy});
      end
   endtask

   task automatic test_load();
      int nhs = 0;
      logic ph = 1'b1;
      clear_logs();
      send_cmd(1'b0, 14'h0010, 15'd8);
      for (int c = 0; c < 40 && nhs < 8; c++) begin
         wr_valid = ph;
         wr_data  = 32'hD000_0010 + nhs;
         if (c == 0) begin
            n_cmp++;
            if (wr_ready !== 1'b1) begin
               n_err++;
               $display("FAIL load_wr_ready: got %b expected 1", wr_ready);
            end
         end
         if (ph && wr_ready) nhs++;
         ph = ~ph;
         cyc();
      end
      wr_valid = 1'b0;
      n_cmp++;
      if (nhs != 8) begin
         n_err++;
         $display("FAIL load_timeout: got %0d handshakes expected 8", nhs);
      end
      n_cmp++;
      if ({done, buf_enaA, buf_weA, buf_addrA, buf_diA} !== {3'b111, 14'h0017, 32'hD000_0017}) begin
         n_err++;
         $display("FAIL load_final_write: got %h expected %h",
                  {done, buf_enaA, buf_weA, buf_addrA, buf_diA}, {3'b111, 14'h0017, 32'hD000_0017});
      end
      cyc();
      n_cmp++;
      if ({done, cmd_ready, buf_enaA} !== 3'b010) begin
         n_err++;
         $display("FAIL load_after_done: got %b expected 010", {done, cmd_ready, buf_enaA});
      end
      n_cmp++;
      if (wa_addr.size() != 8 || done_cnt != 1) begin
         n_err++;
         $display("FAIL load_count: got %0d writes %0d dones expected 8 1", wa_addr.size(), done_cnt);
      end else begin
         for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (wa_addr[i] !== 14'h0010 + 14'(i) || wa_data[i] !== 32'hD000_0010 + i) begin
               n_err++;
               $display("FAIL load_write_%0d: got %h/%h expected %h/%h", i, wa_addr[i], wa_data[i],
                        14'h0010 + 14'(i), 32'hD000_0010 + i);
            end
         end
      end
   endtask

   task automatic test_read();
      clear_logs();
      rd_ready = 1'b1;
      send_cmd(1'b1, 14'h0004, 15'd2);
      n_cmp++;
      if ({rd_valid, buf_enaB, buf_addrB} !== {2'b01, 12'h004}) begin
         n_err++;
         $display("FAIL read_issue0: got %h expected %h", {rd_valid, buf_enaB, buf_addrB}, {2'b01, 12'h004});
      end
      cyc();
      n_cmp++;
      if (rd_valid !== 1'b0) begin
         n_err++;
         $display("FAIL read_latency: got rd_valid=%b expected 0", rd_valid);
      end
      cyc();
      n_cmp++;
      if (rd_valid !== 1'b1 || rd_data !== 128'hD000_0013_D000_0012_D000_0011_D000_0010) begin
         n_err++;
         $display("FAIL read_row4: got %b %h expected 1 %h", rd_valid, rd_data,
                  128'hD000_0013_D000_0012_D000_0011_D000_0010);
      end
      cyc();
      n_cmp++;
      if (rd_valid !== 1'b1 || done !== 1'b0 ||
          rd_data !== 128'hD000_0017_D000_0016_D000_0015_D000_0014) begin
         n_err++;
         $display("FAIL read_row5: got %b %b %h expected 1 0 %h", rd_valid, done, rd_data,
                  128'hD000_0017_D000_0016_D000_0015_D000_0014);
      end
      cyc();
      n_cmp++;
      if ({done, rd_valid} !== 2'b10) begin
         n_err++;
         $display("FAIL read_done: got %b expected 10", {done, rd_valid});
      end
      rd_ready = 1'b0;
      cyc();
      n_cmp++;
      if (rb_addr.size() != 2 || rb_addr[0] !== 12'h004 || rb_addr[1] !== 12'h005 || done_cnt != 1) begin
         n_err++;
         $display("FAIL read_issues: got %0d issues %0d dones expected 2 1", rb_addr.size(), done_cnt);
      end
   endtask

   task automatic test_backpressure();
      int nb = 0;
      logic held_v = 1'b0;
      logic [127:0] held_d = '0;
      logic [127:0] exp;
      for (int i = 0; i < 64; i++) mem[14'h0400 + 14'(i)] = 32'hB000_0400 + i;
      clear_logs();
      rd_ready = 1'b0;
      send_cmd(1'b1, 14'h0100, 15'd16);
      for (int c = 0; c < 300 && nb < 16; c++) begin
         rd_ready = 1'($urandom_range(0, 1));
         if (held_v) begin
            n_cmp++;
            if (rd_valid !== 1'b1 || rd_data !== held_d) begin
               n_err++;
               $display("FAIL bp_hold: got %b %h expected 1 %h", rd_valid, rd_data, held_d);
            end
         end
         if (rd_valid && rd_ready) begin
            for (int w = 0; w < 4; w++) exp[w*32 +: 32] = 32'hB000_0400 + 4 * nb + w;
            n_cmp++;
            if (rd_data !== exp) begin
               n_err++;
               $display("FAIL bp_row_%0d: got %h expected %h", nb, rd_data, exp);
            end
            nb++;
         end
         held_v = rd_valid && !rd_ready;
         held_d = rd_data;
         cyc();
      end
      rd_ready = 1'b0;
      n_cmp++;
      if (nb != 16 || done !== 1'b1) begin
         n_err++;
         $display("FAIL bp_complete: got %0d rows done=%b expected 16 1", nb, done);
      end
      cyc();
      n_cmp++;
      if (max_occ > 2 || valid_err != 0 || port_clash != 0 || done_cnt != 1) begin
         n_err++;
         $display("FAIL bp_fifo: got occ=%0d verr=%0d clash=%0d dones=%0d expected <=2 0 0 1",
                  max_occ, valid_err, port_clash, done_cnt);
      end
      n_cmp++;
      if (rb_addr.size() != 16) begin
         n_err++;
         $display("FAIL bp_issue_count: got %0d expected 16", rb_addr.size());
      end else begin
         for (int i = 0; i < 16; i++) begin
            if (rb_addr[i] !== 12'h100 + 12'(i)) begin
               n_err++;
               $display("FAIL bp_issue_order: got %h expected %h", rb_addr[i], 12'h100 + 12'(i));
               break;
            end
         end
      end
   endtask

   task automatic test_wrap();
      logic [13:0] exp_a [4] = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
      clear_logs();
      send_cmd(1'b0, 14'h3FFE, 15'd4);
      wr_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wr_data = 32'hE000_0000 + k;
         cyc();
      end
      wr_valid = 1'b0;
      cyc();
      n_cmp++;
      if (wa_addr.size() != 4) begin
         n_err++;
         $display("FAIL wrap_write_count: got %0d expected 4", wa_addr.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (wa_addr[k] !== exp_a[k]) begin
               n_err++;
               $display("FAIL wrap_addr_%0d: got %h expected %h", k, wa_addr[k], exp_a[k]);
            end
         end
      end
      clear_logs();
      rd_ready = 1'b1;
      send_cmd(1'b1, 14'h0FFF, 15'd2);
      cyc();
      cyc();
      n_cmp++;
      if (rd_valid !== 1'b1 || rd_data !== 128'hE000_0001_E000_0000_0000_0000_0000_0000) begin
         n_err++;
         $display("FAIL wrap_row_fff: got %b %h expected 1 %h", rd_valid, rd_data,
                  128'hE000_0001_E000_0000_0000_0000_0000_0000);
      end
      cyc();
      n_cmp++;
      if (rd_valid !== 1'b1 || rd_data !== 128'h0000_0000_0000_0000_E000_0003_E000_0002) begin
         n_err++;
         $display("FAIL wrap_row_000: got %b %h expected 1 %h", rd_valid, rd_data,
                  128'h0000_0000_0000_0000_E000_0003_E000_0002);
      end
      cyc();
      rd_ready = 1'b0;
      cyc();
      n_cmp++;
      if (rb_addr.size() != 2 || rb_addr[0] !== 12'hFFF || rb_addr[1] !== 12'h000) begin
         n_err++;
         $display("FAIL wrap_addrb: got %0d issues expected FFF then 000", rb_addr.size());
      end
   endtask

   task automatic test_corners();
      clear_logs();
      wr_valid = 1'b1;
      wr_data  = 32'hDEAD_BEEF;
      repeat (3) cyc();
      wr_valid = 1'b0;
      cyc();
      n_cmp++;
      if (wa_addr.size() != 0 || buf_enaA !== 1'b0) begin
         n_err++;
         $display("FAIL idle_write: got %0d writes expected 0", wa_addr.size());
      end
      clear_logs();
      send_cmd(1'b0, 14'h0020, 15'd0);
      n_cmp++;
      if ({done, busy} !== 2'b11) begin
         n_err++;
         $display("FAIL len0_load_done: got %b expected 11", {done, busy});
      end
      cyc();
      n_cmp++;
      if ({done, cmd_ready} !== 2'b01) begin
         n_err++;
         $display("FAIL len0_load_idle: got %b expected 01", {done, cmd_ready});
      end
      send_cmd(1'b1, 14'h0020, 15'd0);
      n_cmp++;
      if ({done, buf_enaB} !== 2'b10) begin
         n_err++;
         $display("FAIL len0_read_done: got %b expected 10", {done, buf_enaB});
      end
      cyc();
      n_cmp++;
      if (wa_addr.size() != 0 || rb_addr.size() != 0 || done_cnt != 2) begin
         n_err++;
         $display("FAIL len0_no_access: got %0d/%0d/%0d expected 0/0/2",
                  wa_addr.size(), rb_addr.size(), done_cnt);
      end
      clear_logs();
      send_cmd(1'b0, 14'h0030, 15'd2);
      cmd_valid = 1'b1;
      cmd_op    = 1'b1;
      cmd_base  = 14'h0000;
      cmd_len   = 15'd5;
      n_cmp++;
      if (cmd_ready !== 1'b0) begin
         n_err++;
         $display("FAIL busy_cmd_ready: got %b expected 0", cmd_ready);
      end
      cyc();
      cyc();
      cmd_valid = 1'b0;
      wr_valid  = 1'b1;
      wr_data   = 32'hC000_0030;
      cyc();
      wr_data   = 32'hC000_0031;
      cyc();
      wr_valid  = 1'b0;
      n_cmp++;
      if (done !== 1'b1) begin
         n_err++;
         $display("FAIL busy_load_done: got %b expected 1", done);
      end
      cyc();
      cyc();
      n_cmp++;
      if ({cmd_ready, busy} !== 2'b10 || rb_addr.size() != 0 || done_cnt != 1) begin
         n_err++;
         $display("FAIL busy_cmd_ignored: got %b %0d issues %0d dones expected 10 0 1",
                  {cmd_ready, busy}, rb_addr.size(), done_cnt);
      end
      n_cmp++;
      if (wa_addr.size() != 2 || wa_addr[0] !== 14'h0030 || wa_addr[1] !== 14'h0031 ||
          wa_data[1] !== 32'hC000_0031) begin
         n_err++;
         $display("FAIL busy_load_writes: got %0d writes expected 0030/0031", wa_addr.size());
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 1'b0;
      cmd_base  = '0;
      cmd_len   = '0;
      wr_valid  = 1'b0;
      wr_data   = '0;
      rd_ready  = 1'b0;
      for (int i = 0; i < 16384; i++) mem[i] = '0;
      clear_logs();
      void'($urandom(32'h5eed));
      test_reset();
      test_load();
      test_read();
      test_backpressure();
      test_wrap();
      test_corners();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
